// File: rtl/rr_grant_pkg.sv
// Shared types and helpers for the round-robin grant controller.
package rr_grant_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_e;

   localparam int unsigned OH_MAX_W = 32;

   // OR of the positions of set bits; exact for one-hot or zero input.
   function automatic logic [OH_MAX_W-1:0] onehot_to_idx(input logic [OH_MAX_W-1:0] oh);
      logic [OH_MAX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < OH_MAX_W; i++) begin
         if (oh[i]) idx = idx | OH_MAX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping at N-1.
module rr_pick
   import rr_grant_pkg::*;
#(
   parameter  int unsigned N  = 3,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx
);

   always_comb begin
      int unsigned j;
      j      = 0;
      onehot = '0;
      for (int unsigned k = 0; k < N; k++) begin
         j = (32'(ptr) + k) % N;
         if ((onehot == '0) && req[IW'(j)]) onehot[IW'(j)] = 1'b1;
      end
   end

   assign valid = |req;
   assign idx   = IW'(onehot_to_idx(OH_MAX_W'(onehot)));

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin owner arbitration with bounded hold and a one-cycle gap between owners.
module rr_grant_ctrl
   import rr_grant_pkg::*;
#(
   parameter  int unsigned N        = 3,
   parameter  int unsigned MAX_HOLD = 8,
   localparam int unsigned IW       = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  done,
   output logic [N-1:0]  gnt,
   output logic          busy,
   output logic [IW-1:0] owner,
   output logic          timeout
);

   localparam int unsigned HW = $clog2(MAX_HOLD + 1);

   state_e        state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic          timeout_q, timeout_d;
   logic          busy_q, busy_d;

   logic          pick_valid;
   logic [N-1:0]  pick_onehot;
   logic [IW-1:0] pick_idx;

   logic          own_done, own_req, at_max, rel;
   logic [IW-1:0] next_ptr;

   rr_pick #(.N(N)) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .valid  (pick_valid),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   // Release conditions only look at the current owner's lines.
   assign own_done = done[owner_q];
   assign own_req  = req[owner_q];
   assign at_max   = (hcnt_q == HW'(MAX_HOLD));
   assign rel      = own_done || !own_req || at_max;
   assign next_ptr = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         hcnt_q    <= '0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         hcnt_q    <= hcnt_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, GAP: state_d = pick_valid ? GRANT : IDLE;
         GRANT:     if (rel) state_d = GAP;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d     = '0;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      hcnt_d    = hcnt_q;
      timeout_d = 1'b0;
      busy_d    = (state_d == GRANT);
      case (state_q)
         IDLE, GAP: begin
            if (pick_valid) begin
               gnt_d   = pick_onehot;
               owner_d = pick_idx;
               hcnt_d  = HW'(1);
            end
         end
         GRANT: begin
            if (rel) begin
               ptr_d     = next_ptr;
               // Only a pure hold-limit release is reported as a timeout.
               timeout_d = !own_done && own_req && at_max;
            end else begin
               gnt_d  = gnt_q;
               hcnt_d = hcnt_q + HW'(1);
            end
         end
         default: ;
      endcase
   end

   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign owner   = owner_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Scoreboard bench for rr_grant_ctrl with N=3, MAX_HOLD=4.
module tb_rr_grant_ctrl;

   localparam int unsigned N        = 3;
   localparam int unsigned MAX_HOLD = 4;
   localparam int unsigned IW       = 2;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  req;
   logic [N-1:0]  done;
   logic [N-1:0]  gnt;
   logic          busy;
   logic [IW-1:0] owner;
   logic          timeout;

   typedef struct packed {
      logic [N-1:0]  gnt;
      logic          busy;
      logic [IW-1:0] owner;
      logic          timeout;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    n_checks;
   int    n_errors;

   rr_grant_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .busy    (busy),
      .owner   (owner),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   // Apply inputs for the next edge and queue the outputs expected after it.
   task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn,
                       input logic [N-1:0] eg, input logic eb, input logic [IW-1:0] eo,
                       input logic et, input string tag);
      exp_t e;
      @(negedge clk);
      rst_n = r;
      req   = rq;
      done  = dn;
      e.gnt = eg; e.busy = eb; e.owner = eo; e.timeout = et;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // Monitor: compare after every active edge for which an expectation is queued.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".gnt"},     32'(gnt),     32'(e.gnt));
            check({t, ".busy"},    32'(busy),    32'(e.busy));
            check({t, ".owner"},   32'(owner),   32'(e.owner));
            check({t, ".timeout"}, 32'(timeout), 32'(e.timeout));
            check({t, ".onehot0"}, 32'($onehot0(gnt)), 32'd1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      clk = 1'b0; rst_n = 1'b0; req = '0; done = '0;
      n_checks = 0; n_errors = 0;

      // Reset held
      step(0, 3'b000, 3'b000, 3'b000, 0, 2'd0, 0, "rst0");
      step(0, 3'b000, 3'b000, 3'b000, 0, 2'd0, 0, "rst1");

      // Single requester, done in 2nd grant cycle, regrant after gap
      step(1, 3'b010, 3'b000, 3'b010, 1, 2'd1, 0, "single.g1");
      step(1, 3'b010, 3'b000, 3'b010, 1, 2'd1, 0, "single.g2");
      step(1, 3'b010, 3'b010, 3'b000, 0, 2'd1, 0, "single.gap");
      step(1, 3'b010, 3'b000, 3'b010, 1, 2'd1, 0, "single.regrant");
      step(1, 3'b000, 3'b000, 3'b000, 0, 2'd1, 0, "single.abandon");
      step(1, 3'b000, 3'b000, 3'b000, 0, 2'd1, 0, "single.idle");

      // Fairness with all requesting
      step(0, 3'b000, 3'b000, 3'b000, 0, 2'd0, 0, "fair.rst");
      step(1, 3'b111, 3'b000, 3'b001, 1, 2'd0, 0, "fair.o0");
      step(1, 3'b111, 3'b001, 3'b000, 0, 2'd0, 0, "fair.gap0");
      step(1, 3'b111, 3'b000, 3'b010, 1, 2'd1, 0, "fair.o1");
      step(1, 3'b111, 3'b010, 3'b000, 0, 2'd1, 0, "fair.gap1");
      step(1, 3'b111, 3'b000, 3'b100, 1, 2'd2, 0, "fair.o2");
      step(1, 3'b111, 3'b100, 3'b000, 0, 2'd2, 0, "fair.gap2");
      step(1, 3'b111, 3'b000, 3'b001, 1, 2'd0, 0, "fair.o0b");
      step(1, 3'b000, 3'b000, 3'b000, 0, 2'd0, 0, "fair.abandon");
      step(1, 3'b000, 3'b000, 3'b000, 0, 2'd0, 0, "fair.idle");

      // Timeout at MAX_HOLD, twice
      step(0, 3'b000, 3'b000, 3'b000, 0, 2'd0, 0, "to.rst");
      step(1, 3'b101, 3'b000, 3'b001, 1, 2'd0, 0, "to.a1");
      step(1, 3'b101, 3'b000, 3'b001, 1, 2'd0, 0, "to.a2");
      step(1, 3'b101, 3'b000, 3'b001, 1, 2'd0, 0, "to.a3");
      step(1, 3'b101, 3'b000, 3'b001, 1, 2'd0, 0, "to.a4");
      step(1, 3'b101, 3'b000, 3'b000, 0, 2'd0, 1, "to.a_rev");
      step(1, 3'b101, 3'b000, 3'b100, 1, 2'd2, 0, "to.b1");
      step(1, 3'b101, 3'b000, 3'b100, 1, 2'd2, 0, "to.b2");
      step(1, 3'b101, 3'b000, 3'b100, 1, 2'd2, 0, "to.b3");
      step(1, 3'b101, 3'b000, 3'b100, 1, 2'd2, 0, "to.b4");
      step(1, 3'b101, 3'b000, 3'b000, 0, 2'd2, 1, "to.b_rev");

      // Coincidence: foreign done ignored, done at hold limit wins over timeout
      step(1, 3'b101, 3'b000, 3'b001, 1, 2'd0, 0, "co.g1");
      step(1, 3'b101, 3'b100, 3'b001, 1, 2'd0, 0, "co.foreign_done");
      step(1, 3'b101, 3'b000, 3'b001, 1, 2'd0, 0, "co.g3");
      step(1, 3'b101, 3'b000, 3'b001, 1, 2'd0, 0, "co.g4");
      step(1, 3'b101, 3'b001, 3'b000, 0, 2'd0, 0, "co.done_at_max");
      step(1, 3'b000, 3'b000, 3'b000, 0, 2'd0, 0, "co.idle");

      // Abandon by dropping req
      step(0, 3'b000, 3'b000, 3'b000, 0, 2'd0, 0, "ab.rst");
      step(1, 3'b011, 3'b000, 3'b001, 1, 2'd0, 0, "ab.g1");
      step(1, 3'b011, 3'b000, 3'b001, 1, 2'd0, 0, "ab.g2");
      step(1, 3'b010, 3'b000, 3'b000, 0, 2'd0, 0, "ab.drop");
      step(1, 3'b010, 3'b000, 3'b010, 1, 2'd1, 0, "ab.next");
      step(1, 3'b000, 3'b000, 3'b000, 0, 2'd1, 0, "ab.rel");
      step(1, 3'b000, 3'b000, 3'b000, 0, 2'd1, 0, "ab.idle");

      // Asynchronous reset mid-grant
      step(1, 3'b001, 3'b000, 3'b001, 1, 2'd0, 0, "async.pre");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async.gnt",  32'(gnt),  32'd0);
      check("async.busy", 32'(busy), 32'd0);
      step(0, 3'b001, 3'b000, 3'b000, 0, 2'd0, 0, "async.hold");
      step(1, 3'b000, 3'b000, 3'b000, 0, 2'd0, 0, "async.post");

      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
